// File: rtl/or_gate_pipe.sv
// or_gate_pipe: pipelined masked NUM_IN-lane OR with sticky accumulator and output FIFO; OR_GATE_PIPE_PARITY_EN adds out_parity
module or_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_mask,
  input  logic                    acc_mode,
  input  logic                    acc_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_any,
`ifdef OR_GATE_PIPE_PARITY_EN
  output logic                    out_parity,
`endif
  output logic [CNT_W-1:0]        out_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] w_raw, w_prev, w_res;
  logic [WIDTH-1:0] r_acc, r_s1_data;
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_cnt;
  logic [CNT_W-1:0] r_count;
  logic             w_full, w_empty, w_accept, w_push, w_pop;

  always_comb begin
    w_raw = '0;
    for (int i = 0; i < NUM_IN; i++) w_raw = w_raw | (in_mask[i] ? in_data[i*WIDTH +: WIDTH] : '0);
  end

  assign w_prev    = acc_clr ? '0 : r_acc;
  assign w_res     = acc_mode ? (w_prev | w_raw) : w_raw;
  // full is the registered occupancy, so a same-cycle pop never makes room for a push
  assign w_full    = r_cnt == (AW+1)'(DEPTH);
  assign w_empty   = r_cnt == '0;
  assign in_ready  = rst_n && (!r_s1_valid || !w_full);
  assign w_accept  = in_valid && in_ready;
  assign w_push    = r_s1_valid && !w_full;
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign out_data  = w_empty ? '0 : r_mem[r_rptr];
  assign out_any   = |out_data;
  assign out_count = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_acc      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_count    <= '0;
    end else begin
      r_s1_valid <= w_accept || (r_s1_valid && !w_push);
      if (w_accept) r_s1_data <= w_res;
      r_acc <= w_accept ? (acc_mode ? w_res : w_prev) : (acc_clr ? '0 : r_acc);
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_cnt <= (w_push && !w_pop) ? r_cnt + 1'b1 : (w_pop && !w_push) ? r_cnt - 1'b1 : r_cnt;
      if (w_pop) r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_s1_data;
  end

`ifdef OR_GATE_PIPE_PARITY_EN
  logic r_par [DEPTH];
  always_ff @(posedge clk) begin
    if (w_push) r_par[r_wptr] <= ^r_s1_data;
  end
  assign out_parity = w_empty ? 1'b0 : r_par[r_rptr];
`endif
endmodule

// File: tb/tb_or_gate_pipe.sv
// tb_or_gate_pipe: vector table, directed corner sequences and random traffic against a queue-based model
module tb_or_gate_pipe;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [3:0]  in_mask = '0;
  logic        acc_mode = 0;
  logic        acc_clr = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [7:0]  out_data;
  logic        out_any;
  logic [15:0] out_count;
`ifdef OR_GATE_PIPE_PARITY_EN
  logic        out_parity;
`endif

  or_gate_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mask(in_mask), .acc_mode(acc_mode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_any(out_any),
`ifdef OR_GATE_PIPE_PARITY_EN
    .out_parity(out_parity),
`endif
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
    logic        mode;
    logic        clr;
    logic [7:0]  exp;
  } vec_t;

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] q[$];
  logic [7:0] m_acc = '0;
  logic [15:0] m_count = '0;
  logic       acc_seen = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] raw_of(logic [31:0] d, logic [3:0] m);
    logic [7:0] r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r = r | d[i*8 +: 8];
    return r;
  endfunction

  // Called at a negedge with inputs already driven; observes handshakes, then advances one cycle.
  task automatic tick();
    logic [7:0] e, prev, res;
    #1;
    acc_seen = 0;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_pop", 1, 0);
        else begin
          e = q.pop_front();
          check("pop_data", out_data, e);
          check("pop_any", out_any, |e);
`ifdef OR_GATE_PIPE_PARITY_EN
          check("pop_parity", out_parity, ^e);
`endif
          m_count++;
        end
      end
      if (in_valid && in_ready) begin
        prev = acc_clr ? 8'h00 : m_acc;
        res = acc_mode ? (prev | raw_of(in_data, in_mask)) : raw_of(in_data, in_mask);
        m_acc = acc_mode ? res : prev;
        q.push_back(res);
        acc_seen = 1;
      end else if (acc_clr) m_acc = '0;
    end else begin
      q.delete();
      m_acc = '0;
      m_count = '0;
    end
    @(posedge clk);
    @(negedge clk);
    check("out_count", out_count, m_count);
  endtask

  task automatic send(logic [31:0] d, logic [3:0] m, logic md, logic c);
    int n = 0;
    in_data = d; in_mask = m; acc_mode = md; acc_clr = c; in_valid = 1;
    do begin tick(); n++; end while (!acc_seen && n < 50);
    if (!acc_seen) check("send_timeout", 0, 1);
    in_valid = 0; acc_clr = 0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("wait_valid", out_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 0; out_ready = 1;
    while ((q.size() != 0 || out_valid) && n < 40) begin tick(); n++; end
    check("drain_empty", q.size(), 0);
    check("drain_valid", out_valid, 0);
    out_ready = 0;
  endtask

  initial begin
    vec_t tbl[7];
    int accepts, n;
    logic [15:0] base;
    tbl[0] = '{32'h11F00FFF, 4'b0100, 1'b0, 1'b0, 8'hF0};
    tbl[1] = '{32'h11F00FFF, 4'b0000, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{32'h11F00FFF, 4'b1111, 1'b0, 1'b0, 8'hFF};
    tbl[3] = '{32'h00000001, 4'b0001, 1'b1, 1'b0, 8'h01};
    tbl[4] = '{32'h00000010, 4'b0001, 1'b1, 1'b0, 8'h11};
    tbl[5] = '{32'h00000040, 4'b0001, 1'b1, 1'b0, 8'h51};
    tbl[6] = '{32'h00000002, 4'b0001, 1'b1, 1'b1, 8'h02};

    @(negedge clk);
    repeat (2) tick();
    check("rst_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_any", out_any, 0);
`ifdef OR_GATE_PIPE_PARITY_EN
    check("rst_parity", out_parity, 0);
`endif
    rst_n = 1;
    #1 check("ready_after_rst", in_ready, 1);

    send(32'h80040201, 4'hF, 0, 0);
    check("lat_k", out_valid, 0);
    tick();
    check("lat_k1_valid", out_valid, 1);
    check("lat_data", out_data, 8'h87);
    check("lat_any", out_any, 1);
`ifdef OR_GATE_PIPE_PARITY_EN
    check("lat_parity", out_parity, 0);
`endif
    out_ready = 1; tick(); out_ready = 0;
    check("count_one", out_count, 1);

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].data, tbl[i].mask, tbl[i].mode, tbl[i].clr);
      wait_valid();
      check($sformatf("tbl%0d_data", i), out_data, tbl[i].exp);
      check($sformatf("tbl%0d_any", i), out_any, |tbl[i].exp);
      out_ready = 1; tick(); out_ready = 0;
    end

    // backpressure: S1 plus DEPTH entries absorb five results
    base = m_count; accepts = 0; n = 0;
    in_valid = 1; in_mask = 4'b0001; acc_mode = 0;
    while (accepts < 5 && n < 20) begin
      in_data = 32'(accepts + 1); tick(); n++;
      if (acc_seen) accepts++;
    end
    in_data = 32'd6;
    #1 check("bp_ready_low", in_ready, 0);
    repeat (3) begin tick(); if (acc_seen) accepts++; end
    check("bp_accepts", accepts, 5);
    out_ready = 1; n = 0;
    while (accepts < 6 && n < 20) begin tick(); n++; if (acc_seen) accepts++; end
    check("bp_sixth", accepts, 6);
    drain();
    check("bp_count", out_count, base + 16'd6);

    // steady-state streaming
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 100; i++) begin
      in_data = $urandom; in_mask = 4'($urandom); acc_mode = 1'($urandom); acc_clr = 1'($urandom);
      #1 check("steady_ready", in_ready, 1);
      tick();
      check("steady_accept", acc_seen, 1);
      check("steady_occ", q.size() <= 2, 1);
    end
    acc_clr = 0;
    drain();

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom); out_ready = ($urandom_range(0, 3) != 0);
      in_data = $urandom; in_mask = 4'($urandom); acc_mode = 1'($urandom);
      acc_clr = ($urandom_range(0, 7) == 0);
      tick();
    end
    acc_clr = 0;
    drain();

    // reset with results buffered
    for (int i = 0; i < 3; i++) send(32'h00000080, 4'b0001, 1, 0);
    repeat (2) tick();
    check("pre_rst_q", q.size(), 3);
    check("pre_rst_valid", out_valid, 1);
    rst_n = 0;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_ready", in_ready, 0);
    rst_n = 1;
    #1 check("post_rst_ready", in_ready, 1);
    send(32'h00000005, 4'b0001, 1, 0);
    check("post_rst_lat_k", out_valid, 0);
    tick();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 8'h05);
    out_ready = 1; tick(); out_ready = 0;
    check("post_rst_count", out_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
